// File: rtl/bus_arbiter3_pkg.sv
// Shared types, encodings and the round-robin pick used by the three-way bus arbiter.
// The arbiter and its bus mux both import this package.
package bus_arbiter3_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;

    localparam int unsigned IDX_A = 0;
    localparam int unsigned IDX_B = 1;
    localparam int unsigned IDX_C = 2;

    localparam logic [2:0] GNT_NONE = 3'b000;
    localparam logic [2:0] GNT_A    = 3'b001;
    localparam logic [2:0] GNT_B    = 3'b010;
    localparam logic [2:0] GNT_C    = 3'b100;

    // Search starts just after last_gnt (A -> B -> C -> A); excluded requesters never win.
    function automatic logic [2:0] rr_pick(input logic [2:0] req,
                                           input logic [2:0] last_gnt,
                                           input logic [2:0] excl);
        logic [2:0] cand;
        logic [2:0] win;
        cand = req & ~excl;
        win  = GNT_NONE;
        case (last_gnt)
            GNT_A: begin
                if (cand[IDX_B])      win = GNT_B;
                else if (cand[IDX_C]) win = GNT_C;
                else if (cand[IDX_A]) win = GNT_A;
                else                  win = GNT_NONE;
            end
            GNT_B: begin
                if (cand[IDX_C])      win = GNT_C;
                else if (cand[IDX_A]) win = GNT_A;
                else if (cand[IDX_B]) win = GNT_B;
                else                  win = GNT_NONE;
            end
            default: begin
                if (cand[IDX_A])      win = GNT_A;
                else if (cand[IDX_B]) win = GNT_B;
                else if (cand[IDX_C]) win = GNT_C;
                else                  win = GNT_NONE;
            end
        endcase
        return win;
    endfunction

    function automatic logic [1:0] sel_of(input logic [2:0] onehot);
        logic [1:0] s;
        case (onehot)
            GNT_B:   s = SEL_B;
            GNT_C:   s = SEL_C;
            default: s = SEL_A;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bus_arbiter3_mux3to1.sv
// Three-input bus multiplexer steered by the arbiter's registered select.
module mux3to1
    import bus_arbiter3_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    output logic [W-1:0] y
);

    // Select 11 never occurs; it falls back to requester A like the idle case.
    always_comb begin
        y = d0;
        case (sel)
            SEL_A:   y = d0;
            SEL_B:   y = d1;
            SEL_C:   y = d2;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/bus_arbiter3.sv
// Round-robin arbiter for three requesters with a bounded hold time per grant.
// Grant and select are registered; the shared bus is a mux driven by the registered select.
module bus_arbiter3
    import bus_arbiter3_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int W        = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   req,
    input  logic [W-1:0] data_a,
    input  logic [W-1:0] data_b,
    input  logic [W-1:0] data_c,
    output logic [2:0]   gnt,
    output logic [1:0]   sel,
    output logic [W-1:0] bus_data,
    output logic         bus_valid
);

    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    arb_state_e    state_r;
    arb_state_e    state_s;
    logic [2:0]    gnt_r;
    logic [2:0]    gnt_s;
    logic [1:0]    sel_r;
    logic          bus_valid_r;
    logic [CW-1:0] hold_cnt_r;
    logic [CW-1:0] hold_s;
    logic [2:0]    last_gnt_r;
    logic [2:0]    last_s;
    logic [2:0]    win_s;
    logic          others_s;
    logic          release_s;

    // Next-state: in IDLE gnt_r is zero, so excluding it leaves every requester eligible.
    always_comb begin
        state_s   = state_r;
        gnt_s     = gnt_r;
        hold_s    = hold_cnt_r;
        last_s    = last_gnt_r;
        win_s     = rr_pick(req, last_gnt_r, gnt_r);
        others_s  = |(req & ~gnt_r);
        release_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                release_s = 1'b1;
            end
            ST_GRANT: begin
                if (!(|(req & gnt_r))) begin
                    release_s = 1'b1;
                end else if ((hold_cnt_r == HOLD_LAST) && others_s) begin
                    release_s = 1'b1;
                end else begin
                    release_s = 1'b0;
                end
            end
            default: begin
                release_s = 1'b1;
            end
        endcase

        if (release_s) begin
            if (win_s != GNT_NONE) begin
                state_s = ST_GRANT;
                gnt_s   = win_s;
                hold_s  = '0;
                last_s  = win_s;
            end else begin
                state_s = ST_IDLE;
                gnt_s   = GNT_NONE;
                hold_s  = '0;
            end
        end else if (hold_cnt_r != HOLD_LAST) begin
            hold_s = hold_cnt_r + CW'(1);
        end else begin
            hold_s = hold_cnt_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            gnt_r       <= GNT_NONE;
            sel_r       <= SEL_A;
            bus_valid_r <= 1'b0;
            hold_cnt_r  <= '0;
            last_gnt_r  <= GNT_C;
        end else begin
            state_r     <= state_s;
            gnt_r       <= gnt_s;
            sel_r       <= sel_of(gnt_s);
            bus_valid_r <= |gnt_s;
            hold_cnt_r  <= hold_s;
            last_gnt_r  <= last_s;
        end
    end

    assign gnt       = gnt_r;
    assign sel       = sel_r;
    assign bus_valid = bus_valid_r;

    mux3to1 #(.W(W)) u_bus_mux (
        .sel (sel_r),
        .d0  (data_a),
        .d1  (data_b),
        .d2  (data_c),
        .y   (bus_data)
    );

endmodule
